// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and op classification.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the {hi,lo} pair, including divide corner cases.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [2*WIDTH-1:0] a_sext, b_sext, prod_s;
    logic        [2*WIDTH-1:0] a_zext, b_zext, prod_u;
    logic signed [WIDTH-1:0]   a_s, b_div_s, quot_s, rem_s;
    logic        [WIDTH-1:0]   b_div_u, quot_u, rem_u;
    logic                      div_zero, div_ovf;

    always_comb begin
        a_sext = {{WIDTH{a[WIDTH-1]}}, a};
        b_sext = {{WIDTH{b[WIDTH-1]}}, b};
        a_zext = {{WIDTH{1'b0}}, a};
        b_zext = {{WIDTH{1'b0}}, b};
        prod_s = a_sext * b_sext;
        prod_u = a_zext * b_zext;

        // Corner cases get a harmless divisor so the dividers never see /0 or overflow.
        div_zero = (b == '0);
        div_ovf  = (a == MIN_NEG) && (b == '1);
        a_s      = $signed(a);
        b_div_s  = (div_zero || div_ovf) ? $signed(ONE) : $signed(b);
        b_div_u  = div_zero ? ONE : b;
        quot_s   = a_s / b_div_s;
        rem_s    = a_s % b_div_s;
        quot_u   = a / b_div_u;
        rem_u    = a % b_div_u;

        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else if (div_ovf) begin
                    res_hi = '0;
                    res_lo = MIN_NEG;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: result is computed at launch, held in shadow registers and
// committed to HI/LO after a fixed busy window, unless cancelled by a flush.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic [WIDTH-1:0]       shadow_hi_q, shadow_hi_d;
    logic [WIDTH-1:0]       shadow_lo_q, shadow_lo_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic [WIDTH-1:0]       res_hi, res_lo;
    logic                   is_mul, is_div;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (md_op),
        .a      (src_a),
        .b      (src_b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign is_mul   = md_is_mul(md_op);
    assign is_div   = md_is_div(md_op);
    assign busy     = busy_q;
    assign md_stall = busy_q | (start & (is_mul | is_div));
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        hi_d        = hi_q;
        lo_d        = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    if (is_mul || is_div) begin
                        shadow_hi_d = res_hi;
                        shadow_lo_d = res_lo;
                        cnt_d       = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        busy_d      = 1'b1;
                        state_d     = ST_RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = src_a;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            ST_RUN: begin
                // A flush drops the shadow result; HI/LO are untouched.
                if (cancel) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    hi_d    = shadow_hi_q;
                    lo_d    = shadow_lo_q;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

endmodule
